usb_token_tx_sched: RTL and testbench

Transmit scheduler for the USB token/handshake packet generator. It arbitrates between the host token requester (OUT/IN/SETUP/SOF) and the handshake requester (ACK/NAK/STALL from the receive path), and presents one packet at a time on the generator's `pid/addr/endp/valid/ready` interface. It drives `crc5_en` for the whole packet, waits for the end-of-packet marker, enforces an inter-packet gap, and recovers from a stalled generator by timeout.

---
 rtl/usb_token_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_usb_token_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_token_tx_sched.sv
// Transmit scheduler for the USB token/handshake packet generator.
// Arbitrates token vs handshake requests and paces packets with EOP, IPG and timeout.
module usb_token_tx_sched #(
  parameter int unsigned IPG_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sched_en,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [3:0] tok_pid,
  input  logic [6:0] tok_addr,
  input  logic [3:0] tok_endp,
  input  logic       hs_valid,
  output logic       hs_ready,
  input  logic [3:0] hs_pid,
  output logic [3:0] gen_pid,
  output logic [6:0] gen_addr,
  output logic [3:0] gen_endp,
  output logic       gen_valid,
  input  logic       gen_ready,
  input  logic       gen_eop,
  output logic       crc5_en,
  output logic       busy,
  output logic       err_pid,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(IPG_CYCLES - 1);

  state_t      r_state;
  logic        r_last_hs;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_gap_cnt;
  logic [3:0]  r_pid;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic        r_gen_valid;
  logic        r_crc;
  logic        r_err_pid;
  logic        r_err_to;

  logic w_can_grant;
  logic w_pick_hs;
  logic w_take_hs;
  logic w_take_tok;
  logic w_hs_legal;
  logic w_tok_legal;

  // Readies are gated by reset so nothing transfers while held in reset.
  assign w_can_grant = rst & (r_state == S_IDLE)
                     & sched_en & gen_ready;
  assign w_pick_hs   = hs_valid & (~tok_valid | ~r_last_hs);
  assign w_take_hs   = w_can_grant & w_pick_hs;
  assign w_take_tok  = w_can_grant & tok_valid & ~w_pick_hs;

  assign tok_ready   = w_take_tok;
  assign hs_ready    = w_take_hs;

  always_comb begin
    w_hs_legal = 1'b0;
    case (hs_pid)
      4'b0010, 4'b1010, 4'b1110: w_hs_legal = 1'b1;
      default:                   w_hs_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_tok_legal = 1'b0;
    case (tok_pid)
      4'b0001, 4'b1001,
      4'b1101, 4'b0101: w_tok_legal = 1'b1;
      default:          w_tok_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_hs   <= 1'b0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_pid       <= '0;
      r_addr      <= '0;
      r_endp      <= '0;
      r_gen_valid <= 1'b0;
      r_crc       <= 1'b0;
      r_err_pid   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_gen_valid <= 1'b0;
      r_err_pid   <= 1'b0;
      r_err_to    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_take_hs) begin
            if (w_hs_legal) begin
              r_pid       <= hs_pid;
              r_addr      <= '0;
              r_endp      <= '0;
              r_crc       <= 1'b0;
              r_last_hs   <= 1'b1;
              r_gen_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_err_pid <= 1'b1;
            end
          end else if (w_take_tok) begin
            if (w_tok_legal) begin
              r_pid       <= tok_pid;
              r_addr      <= tok_addr;
              r_endp      <= tok_endp;
              r_crc       <= 1'b1;
              r_last_hs   <= 1'b0;
              r_gen_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_err_pid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // EOP takes priority over a coincident timeout.
          if (gen_eop) begin
            r_crc     <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else if (r_to_cnt >= TO_LAST) begin
            r_err_to  <= 1'b1;
            r_crc     <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt >= GAP_LAST) begin
            r_state <= S_IDLE;
          end else if (r_gap_cnt != '1) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gen_pid     = r_pid;
  assign gen_addr    = r_addr;
  assign gen_endp    = r_endp;
  assign gen_valid   = r_gen_valid;
  assign crc5_en     = r_crc;
  assign busy        = (r_state != S_IDLE);
  assign err_pid     = r_err_pid;
  assign err_timeout = r_err_to;

endmodule

// File: tb/tb_usb_token_tx_sched.sv
// Bench for usb_token_tx_sched: directed plan plus random traffic,
// checked each cycle against a timestamp-based model of packet timing.
module tb_usb_token_tx_sched;
  localparam int IPG = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sched_en = 1'b0;
  logic       tok_valid = 1'b0;
  logic [3:0] tok_pid = '0;
  logic [6:0] tok_addr = '0;
  logic [3:0] tok_endp = '0;
  logic       hs_valid = 1'b0;
  logic [3:0] hs_pid = '0;
  logic       gen_ready = 1'b0;
  logic       gen_eop = 1'b0;
  logic       tok_ready, hs_ready;
  logic [3:0] gen_pid, gen_endp;
  logic [6:0] gen_addr;
  logic       gen_valid, crc5_en, busy;
  logic       err_pid, err_timeout;

  usb_token_tx_sched #(
    .IPG_CYCLES(IPG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_pid(tok_pid), .tok_addr(tok_addr),
    .tok_endp(tok_endp),
    .hs_valid(hs_valid), .hs_ready(hs_ready),
    .hs_pid(hs_pid),
    .gen_pid(gen_pid), .gen_addr(gen_addr),
    .gen_endp(gen_endp), .gen_valid(gen_valid),
    .gen_ready(gen_ready), .gen_eop(gen_eop),
    .crc5_en(crc5_en), .busy(busy),
    .err_pid(err_pid), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int c = 0;

  // Model: every packet reduced to the cycle numbers of its events.
  int m_free_at, m_launch_at, m_end_at;
  int m_eop_at, m_errto_at, m_errpid_at;
  bit m_tok, m_last_hs;
  logic [3:0] m_pid, m_endp;
  logic [6:0] m_addr;

  int eop_delay = 2;
  bit tok_keep = 0, hs_keep = 0, stray_eop = 0;
  int obs_kind[$];
  int obs_cyc[$];
  logic [3:0] tok_set[4] = '{4'h1, 4'h9, 4'hD, 4'h5};
  logic [3:0] hs_set[3]  = '{4'h2, 4'hA, 4'hE};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tok_legal(input logic [3:0] p);
    return p inside {4'h1, 4'h9, 4'hD, 4'h5};
  endfunction

  function automatic bit hs_legal(input logic [3:0] p);
    return p inside {4'h2, 4'hA, 4'hE};
  endfunction

  task automatic model_reset();
    m_free_at = 0;    m_launch_at = -1;
    m_end_at = -1;    m_eop_at = -1;
    m_errto_at = -1;  m_errpid_at = -1;
    m_tok = 0;        m_last_hs = 0;
    m_pid = '0; m_addr = '0; m_endp = '0;
  endtask

  task automatic launch(input bit is_hs,
                        input logic [3:0] p,
                        input logic [6:0] a,
                        input logic [3:0] e);
    int w;
    w = c + 2;
    m_launch_at = c + 1;
    if (eop_delay < TMO) begin
      m_end_at = w + eop_delay;
      m_eop_at = m_end_at;
      m_errto_at = -1;
    end else begin
      m_end_at = w + TMO - 1;
      m_eop_at = -1;
      m_errto_at = m_end_at + 1;
    end
    m_free_at = m_end_at + IPG + 1;
    m_tok = !is_hs;
    m_last_hs = is_hs;
    m_pid = p; m_addr = a; m_endp = e;
  endtask

  task automatic step();
    bit idle, gok, et, eh;
    gen_eop = (c == m_eop_at) ||
      (stray_eop && !(c > m_launch_at && c <= m_end_at));
    @(negedge clk);
    idle = (c >= m_free_at);
    gok = idle && sched_en && gen_ready;
    et = gok && tok_valid && (!hs_valid || m_last_hs);
    eh = gok && hs_valid && (!tok_valid || !m_last_hs);
    chk("tok_ready", tok_ready, et);
    chk("hs_ready", hs_ready, eh);
    chk("gen_valid", gen_valid, c == m_launch_at);
    chk("busy", busy, !idle);
    chk("crc5_en", crc5_en,
        m_tok && c >= m_launch_at && c <= m_end_at);
    chk("err_pid", err_pid, c == m_errpid_at);
    chk("err_timeout", err_timeout, c == m_errto_at);
    chk("gen_pid", gen_pid, m_pid);
    chk("gen_addr", gen_addr, m_addr);
    chk("gen_endp", gen_endp, m_endp);
    if (hs_ready && hs_valid) begin
      obs_kind.push_back(1); obs_cyc.push_back(c);
    end else if (tok_ready && tok_valid) begin
      obs_kind.push_back(0); obs_cyc.push_back(c);
    end
    if (eh) begin
      if (hs_legal(hs_pid)) launch(1'b1, hs_pid, '0, '0);
      else m_errpid_at = c + 1;
    end else if (et) begin
      if (tok_legal(tok_pid))
        launch(1'b0, tok_pid, tok_addr, tok_endp);
      else m_errpid_at = c + 1;
    end
    @(posedge clk); #1;
    c++;
    if (eh && !hs_keep) hs_valid = 1'b0;
    if (et && !tok_keep) tok_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    int k = 0;
    while (c < m_free_at && k < 500) begin
      step(); k++;
    end
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int k = 0;
    while (obs_kind.size() < n && k < budget) begin
      step(); k++;
    end
    chk("grants_seen", obs_kind.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    gen_eop = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_hs_ready", hs_ready, 0);
    chk("rst_gen_valid", gen_valid, 0);
    chk("rst_crc5_en", crc5_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_pid", err_pid, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_gen_pid", gen_pid, 0);
    chk("rst_gen_addr", gen_addr, 0);
    chk("rst_gen_endp", gen_endp, 0);
    model_reset();
    @(posedge clk); #1; c++;
    @(posedge clk); #1; c++;
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    #2;
    sched_en = 1; gen_ready = 1;
    tok_valid = 1; hs_valid = 1;
    tok_pid = 4'h1; hs_pid = 4'h2;
    do_reset();
    tok_valid = 0; hs_valid = 0;

    // single OUT, held request shows the EOP+IPG+1 spacing
    obs_kind.delete(); obs_cyc.delete();
    tok_pid = 4'b0001; tok_addr = 7'h15; tok_endp = 4'h3;
    eop_delay = 3; tok_keep = 1; tok_valid = 1;
    run_until_grants(2, 100);
    tok_keep = 0; tok_valid = 0;
    if (obs_cyc.size() >= 2)
      chk("spacing", obs_cyc[1] - obs_cyc[0], 2 + 3 + IPG + 1);
    drain();

    // contention alternates starting with handshake
    obs_kind.delete(); obs_cyc.delete();
    eop_delay = 2; tok_pid = 4'b1001;
    tok_addr = 7'($urandom); tok_endp = 4'($urandom);
    hs_pid = 4'b0010;
    tok_keep = 1; hs_keep = 1; tok_valid = 1; hs_valid = 1;
    run_until_grants(4, 200);
    tok_keep = 0; hs_keep = 0; tok_valid = 0; hs_valid = 0;
    if (obs_kind.size() >= 4) begin
      chk("order0", obs_kind[0], 1);
      chk("order1", obs_kind[1], 0);
      chk("order2", obs_kind[2], 1);
      chk("order3", obs_kind[3], 0);
    end
    drain();

    // illegal PIDs are consumed and dropped
    obs_kind.delete(); obs_cyc.delete();
    hs_pid = 4'b0001; hs_valid = 1; run(4);
    tok_pid = 4'b0010; tok_valid = 1; run(4);
    chk("illegal_accepts", obs_kind.size(), 2);

    // timeout, then EOP on the final timeout cycle
    eop_delay = 1000; tok_pid = 4'b1101; tok_valid = 1;
    run(TMO + IPG + 6); drain();
    eop_delay = TMO - 1; tok_valid = 1;
    run(TMO + IPG + 6); drain();

    // backpressure from the generator
    obs_kind.delete(); obs_cyc.delete();
    eop_delay = 2; gen_ready = 0; tok_pid = 4'b0101; tok_valid = 1;
    run(10);
    chk("bp_hold", obs_cyc.size(), 0);
    gen_ready = 1; c0 = c; step();
    chk("bp_release", obs_cyc.size() == 1 && obs_cyc[0] == c0, 1'b1);
    drain();

    // sched_en dropped mid-packet
    obs_kind.delete(); obs_cyc.delete();
    eop_delay = 10; tok_pid = 4'b0001; tok_valid = 1;
    run(4);
    sched_en = 0; tok_valid = 1;
    run(30);
    chk("en_off_grants", obs_cyc.size(), 1);
    sched_en = 1; run(2); drain();

    // reset while waiting for EOP
    eop_delay = 20; tok_pid = 4'b1001;
    tok_addr = 7'h2A; tok_endp = 4'h7; tok_valid = 1;
    run(6);
    tok_valid = 1;
    do_reset();
    run(3); drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!tok_valid && $urandom_range(0, 2) == 0) begin
        tok_valid = 1;
        tok_pid = ($urandom_range(0, 7) == 0) ?
          4'($urandom) : tok_set[$urandom_range(0, 3)];
        tok_addr = 7'($urandom);
        tok_endp = 4'($urandom);
      end
      if (!hs_valid && $urandom_range(0, 2) == 0) begin
        hs_valid = 1;
        hs_pid = ($urandom_range(0, 7) == 0) ?
          4'($urandom) : hs_set[$urandom_range(0, 2)];
      end
      gen_ready = ($urandom_range(0, 7) != 0);
      sched_en = ($urandom_range(0, 15) != 0);
      stray_eop = ($urandom_range(0, 9) == 0);
      eop_delay = ($urandom_range(0, 15) == 0) ?
        100 : int'($urandom_range(0, 12));
      step();
    end
    stray_eop = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
